handle_mem_port: RTL and testbench
==================================

Name: handle_mem_port

Overview:
- Downstream stage of the handle translator. It consumes that stage's physical request stream: op, translated address and data, one request per cycle, with no back-pressure.
- Buffers requests in an in-order FIFO and executes them against a word-addressed backing RAM whose access time is configurable.
- Returns read results on a one-cycle valid pulse.
- Sits between the handle translator and memory, and absorbs short bursts while memory is slow.

Parameters:
- FIFO_DEPTH_LOG2, 2: FIFO holds 2**FIFO_DEPTH_LOG2 requests (4).
- MEM_WORDS, 256: backing RAM size in words; must be a power of two.
- MEM_LATENCY, 2: cycles per RAM access; must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_op  in  3  request op: `READ, `WRITE, anything else is no-op.
- i_address  in  `ADDR_WIDTH  physical word address.
- i_data  in  `ADDR_WIDTH  write data.
- o_rd_valid  out  1  one-cycle pulse: read completed.
- o_rd_address  out  `ADDR_WIDTH  address of the completed read.
- o_rd_data  out  `ADDR_WIDTH  read result.
- o_busy  out  1  FIFO non-empty or access in flight.
- o_overflow  out  1  sticky: a request was dropped.
- o_err  out  1  out-of-range pulse; exists only under the optional feature, else tied 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count cleared; FSM goes to IDLE; counter cleared.
  - o_rd_valid, o_rd_address, o_rd_data, o_overflow and o_err all 0.
  - RAM contents are not reset.
  - Reset during BUSY abandons the in-flight request; a pending write is not performed.
- Push, evaluated each rising edge:
  - Push only when i_op is `READ or `WRITE; other codes are ignored.
  - FIFO full with no pop this edge: request dropped, o_overflow set to 1 until reset.
  - Push and pop on the same edge while full: push accepted.
  - No bypass path: an entry pushed at edge N is popped no earlier than edge N+1.
- FSM states: IDLE and BUSY.
  - IDLE, FIFO non-empty: pop head into the current-request register, load counter = MEM_LATENCY-1, go to BUSY.
  - BUSY, counter != 0: decrement counter.
  - BUSY, counter == 0: perform the access.
    - Write: mem[idx] <= data.
    - Read: o_rd_data <= mem[idx], o_rd_address <= address, o_rd_valid high for exactly the following cycle.
    - Then, if FIFO non-empty, pop the next request and reload the counter (back-to-back, no idle cycle); otherwise go to IDLE.
- Timing:
  - Read pushed at edge N into an idle, empty block: o_rd_valid is high between edges N+1+MEM_LATENCY and N+2+MEM_LATENCY.
  - Sustained throughput: one access per MEM_LATENCY cycles.
- Addressing: idx = i_address[$clog2(MEM_WORDS)-1:0]; upper bits are ignored (aliasing).
- Ordering: strictly FIFO; read-after-write to the same address returns the new data.
- o_busy is combinational: (state == BUSY) | ~empty.

Optional Feature:
- Macro: HANDLE_MEM_BOUNDS_CHECK_EN.
- Defined: a request with address >= MEM_WORDS is still queued and timed normally, but:
  - a write is suppressed;
  - a read returns o_rd_data = 0 with o_rd_valid;
  - o_err pulses in the same cycle as that request's completion slot (for writes too).
- Undefined: no comparison logic; addresses alias; o_err is tied 0.

Decomposition:
- Shared header (existing `include):
  - `ADDR_WIDTH, `HNDL_WIDTH;
  - op codes `READ and `WRITE;
  - op width constant (3).
- One sub-module: req_fifo, a synchronous FIFO parameterised on WIDTH and DEPTH_LOG2, with push/pop/full/empty and async active-low reset. Entry width = 3 + 2*`ADDR_WIDTH.
- RAM array and FSM stay in handle_mem_port.

Test Plan:
- Write addr 0x10 data 0xAB, then read 0x10 (MEM_LATENCY=2) -> o_rd_valid single pulse, o_rd_address=0x10, o_rd_data=0xAB, 3 edges after the read push when idle.
- 7 writes on consecutive edges, MEM_LATENCY=4, depth 4 -> first 6 accepted, 7th dropped, o_overflow=1 and stays 1; readback of the 7th address returns its prior value.
- i_op=0 and i_op=3 held for 10 cycles -> no push, o_busy=0, no o_rd_valid.
- Write 0x05 <= 5 immediately followed by read 0x05 on the next edge -> read returns 5.
- Write 0x20 <= 0x77 (old value 0x11), rst_n pulsed low while BUSY -> all outputs 0 at once, o_busy=0; later read of 0x20 returns 0x11.
- With HANDLE_MEM_BOUNDS_CHECK_EN, read address MEM_WORDS -> o_rd_valid with o_err=1, data 0. Without the macro, the same read returns mem[0], o_err=0.

Source files
------------

// File: rtl/handle_mem_port_pkg.sv
// Shared definitions for the handle memory port: request layout, op codes,
// FSM states. The `define block below is the translator's shared header.
`ifndef HANDLE_SHARED_DEFS
`define HANDLE_SHARED_DEFS
`define ADDR_WIDTH 16
`define HNDL_WIDTH 8
`define OP_WIDTH   3
`define READ       3'd1
`define WRITE      3'd2
`endif

package handle_mem_port_pkg;

  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int OP_W   = `OP_WIDTH;

  localparam logic [OP_W-1:0] OP_READ  = `READ;
  localparam logic [OP_W-1:0] OP_WRITE = `WRITE;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  // One queued physical request as delivered by the translator.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // Only reads and writes occupy a FIFO slot; every other code is a no-op.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/handle_mem_port_req_fifo.sv
// In-order request FIFO: 2**DEPTH_LOG2 entries, no bypass from push to pop.
// A push while full is accepted only if a pop happens on the same edge.
module req_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      storage [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = storage[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  // NOTE: storage has no reset; only pointers and count define validity, so
  // clearing the array would cost a reset net per bit for no behavioural gain.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/handle_mem_port.sv
// Memory stage behind the handle translator: queues read/write requests in a
// FIFO and executes them in order against a word-addressed RAM whose access
// takes MEM_LATENCY cycles. Read results come back on a one-cycle pulse.
// Optional build macro: HANDLE_MEM_BOUNDS_CHECK_EN -- addresses >= MEM_WORDS
// are flagged on o_err, writes to them are suppressed and reads return 0.
module handle_mem_port
  import handle_mem_port_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int MEM_WORDS       = 256,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_W-1:0]        i_op,
  input  logic [`ADDR_WIDTH-1:0] i_address,
  input  logic [`ADDR_WIDTH-1:0] i_data,
  output logic                   o_rd_valid,
  output logic [`ADDR_WIDTH-1:0] o_rd_address,
  output logic [`ADDR_WIDTH-1:0] o_rd_data,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic                   o_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state;
  state_t            state_next;
  req_t              cur;
  req_t              fifo_head;
  req_t              push_req;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]  idx;

  logic push;
  logic pop;
  logic access;
  logic in_range;
  logic do_write;
  logic do_read;
  logic fifo_full;
  logic fifo_empty;

  assign push_req = '{op: i_op, addr: i_address, data: i_data};
  assign push     = is_mem_op(i_op);
  assign idx      = cur.addr[IDX_W-1:0];
  assign o_busy   = (state == ST_BUSY) | ~fifo_empty;

  req_fifo #(
    .WIDTH      (REQ_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
  // Out of range means any address bit above the RAM index is set.
  assign in_range = ((cur.addr >> IDX_W) == '0);
`else
  assign in_range = 1'b1;
`endif

  // FSM state register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state: leave IDLE on work, return only when the last access
  // completes with nothing queued behind it.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (!fifo_empty) state_next = ST_BUSY;
      ST_BUSY: if ((cnt == '0) && fifo_empty) state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: access slot and pop decision for this edge.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    access = 1'b0;
    pop    = 1'b0;
    unique case (state)
      ST_IDLE: pop = ~fifo_empty;
      ST_BUSY: begin
        if (cnt == '0) begin
          access = 1'b1;
          pop    = ~fifo_empty;
        end
      end
    endcase
  end

  assign do_write = access & (cur.op == OP_WRITE) & in_range;
  assign do_read  = access & (cur.op == OP_READ);

  // Current request register and access-time counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      cnt <= '0;
    end else if (pop) begin
      cur <= fifo_head;
      cnt <= CNT_LOAD;
    end else if ((state == ST_BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Backing RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= cur.data;
  end

  // Read completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_valid   <= 1'b0;
      o_rd_address <= '0;
      o_rd_data    <= '0;
    end else begin
      o_rd_valid <= do_read;
      if (do_read) begin
        o_rd_address <= cur.addr;
        o_rd_data    <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Sticky flag: a request arrived while full with no pop to make room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            o_overflow <= 1'b0;
    else if (push & fifo_full & ~pop)      o_overflow <= 1'b1;
  end

`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
  // Out-of-range pulse aligned with the request's completion slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_err <= 1'b0;
    else        o_err <= access & ~in_range;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_handle_mem_port.sv
// Bench for handle_mem_port: random and directed requests checked each cycle
// against a schedule-based reference model (pop/completion edges computed
// arithmetically from arrival edges, memory kept as a plain array).
module tb_handle_mem_port;
  import handle_mem_port_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int MW    = 256;
  localparam int LAT   = 4;
  localparam int DLOG2 = 2;
  localparam int DEPTH = 1 << DLOG2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    i_op;
  logic [AW-1:0] i_address;
  logic [AW-1:0] i_data;
  logic          o_rd_valid;
  logic [AW-1:0] o_rd_address;
  logic [AW-1:0] o_rd_data;
  logic          o_busy;
  logic          o_overflow;
  logic          o_err;

  handle_mem_port #(
    .FIFO_DEPTH_LOG2 (DLOG2),
    .MEM_WORDS       (MW),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_op         (i_op),
    .i_address    (i_address),
    .i_data       (i_data),
    .o_rd_valid   (o_rd_valid),
    .o_rd_address (o_rd_address),
    .o_rd_data    (o_rd_data),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each accepted request knows its pop edge and its
  // completion edge; memory effects are applied at the completion edge.
  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
    int            start;
    int            acc;
  } mreq_t;

  mreq_t         q[$];
  logic [AW-1:0] mmem [MW];
  int            edge_n   = 0;
  int            last_acc = 0;
  bit            exp_ovf  = 0;
  bit            exp_valid;
  bit            exp_err;
  logic [AW-1:0] exp_addr;
  logic [AW-1:0] exp_data;

  // Observations gathered by tick for the directed tests.
  int            valid_edges[$];
  logic [AW-1:0] last_rd_data;
  logic [AW-1:0] last_rd_addr;
  int            err_seen = 0;

  task automatic model_reset();
    q.delete();
    last_acc = 0;
    exp_ovf  = 0;
  endtask

  task automatic model_edge(input logic [2:0] op, input logic [AW-1:0] addr,
                            input logic [AW-1:0] data);
    int    e;
    int    in_fifo;
    bit    pop_now;
    bit    oob;
    mreq_t r;
    e         = edge_n;
    exp_valid = 0;
    exp_err   = 0;
    if (op == OP_READ || op == OP_WRITE) begin
      in_fifo = 0;
      pop_now = 0;
      foreach (q[i]) begin
        if (q[i].start >= e) in_fifo++;
        if (q[i].start == e) pop_now = 1;
      end
      if (in_fifo < DEPTH || pop_now) begin
        r.op    = op;
        r.addr  = addr;
        r.data  = data;
        r.start = (e + 1 > last_acc) ? e + 1 : last_acc;
        r.acc   = r.start + LAT;
        last_acc = r.acc;
        q.push_back(r);
      end else begin
        exp_ovf = 1;
      end
    end
    if (q.size() > 0 && q[0].acc == e) begin
      r   = q.pop_front();
      oob = 0;
`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
      oob = (int'(r.addr) >= MW);
      exp_err = oob;
`endif
      if (r.op == OP_WRITE && !oob) mmem[int'(r.addr) % MW] = r.data;
      if (r.op == OP_READ) begin
        exp_valid = 1;
        exp_addr  = r.addr;
        exp_data  = oob ? '0 : mmem[int'(r.addr) % MW];
      end
    end
  endtask

  // Drive one request at the falling edge, step one rising edge, compare all
  // outputs against the model at the next falling edge.
  task automatic tick(input logic [2:0] op, input logic [AW-1:0] addr,
                      input logic [AW-1:0] data);
    bit exp_busy;
    i_op      = op;
    i_address = addr;
    i_data    = data;
    @(posedge clk);
    edge_n++;
    model_edge(op, addr, data);
    @(negedge clk);
    exp_busy = (q.size() != 0);
    checks++;
    if (o_rd_valid !== exp_valid) begin
      errors++;
      $display("FAIL rd_valid @edge %0d: got %b expected %b", edge_n, o_rd_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (o_rd_address !== exp_addr) begin
        errors++;
        $display("FAIL rd_address @edge %0d: got %h expected %h", edge_n, o_rd_address, exp_addr);
      end
      checks++;
      if (o_rd_data !== exp_data) begin
        errors++;
        $display("FAIL rd_data @edge %0d: got %h expected %h", edge_n, o_rd_data, exp_data);
      end
    end
    checks++;
    if (o_err !== exp_err) begin
      errors++;
      $display("FAIL err @edge %0d: got %b expected %b", edge_n, o_err, exp_err);
    end
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow @edge %0d: got %b expected %b", edge_n, o_overflow, exp_ovf);
    end
    checks++;
    if (o_busy !== exp_busy) begin
      errors++;
      $display("FAIL busy @edge %0d: got %b expected %b", edge_n, o_busy, exp_busy);
    end
    if (o_rd_valid === 1'b1) begin
      valid_edges.push_back(edge_n);
      last_rd_data = o_rd_data;
      last_rd_addr = o_rd_address;
    end
    if (o_err === 1'b1) err_seen++;
  endtask

  task automatic nop();
    tick(3'd0, '0, '0);
  endtask

  // Idle until the model says everything has completed, bounded.
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      nop();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) nop();
    checks++;
    if (o_rd_data !== '0 || o_rd_address !== '0) begin
      errors++;
      $display("FAIL reset_rd_regs: got addr %h data %h expected 0 0", o_rd_address, o_rd_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic preload();
    for (int i = 0; i < MW; i++) begin
      tick(OP_WRITE, AW'(i), (i == 16'h46) ? 16'h1234 : AW'($urandom));
      repeat (LAT) nop();
    end
    drain();
  endtask

  task automatic test_write_read();
    int n0;
    int e_push;
    tick(OP_WRITE, 16'h0010, 16'h00AB);
    drain();
    n0 = valid_edges.size();
    tick(OP_READ, 16'h0010, '0);
    e_push = edge_n;
    drain();
    nop();
    checks++;
    if (valid_edges.size() - n0 != 1) begin
      errors++;
      $display("FAIL wr_rd_pulses: got %0d expected 1", valid_edges.size() - n0);
    end else begin
      checks++;
      if (valid_edges[$] != e_push + 1 + LAT) begin
        errors++;
        $display("FAIL wr_rd_latency: got edge %0d expected %0d", valid_edges[$], e_push + 1 + LAT);
      end
    end
    checks++;
    if (last_rd_data !== 16'h00AB || last_rd_addr !== 16'h0010) begin
      errors++;
      $display("FAIL wr_rd_value: got %h@%h expected 00ab@0010", last_rd_data, last_rd_addr);
    end
  endtask

  task automatic test_noop();
    int n0;
    n0 = valid_edges.size();
    repeat (10) tick(3'd0, AW'($urandom), AW'($urandom));
    repeat (10) tick(3'd3, AW'($urandom), AW'($urandom));
    checks++;
    if (valid_edges.size() != n0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL noop: got %0d pulses busy %b expected 0 pulses busy 0",
               valid_edges.size() - n0, o_busy);
    end
  endtask

  task automatic test_raw();
    tick(OP_WRITE, 16'h0005, 16'h0005);
    tick(OP_READ, 16'h0005, '0);
    drain();
    checks++;
    if (last_rd_data !== 16'h0005) begin
      errors++;
      $display("FAIL raw: got %h expected 0005", last_rd_data);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      tick(OP_WRITE, AW'(16'h40 + i), AW'(16'hC0 + i));
      if (i == 5) begin
        checks++;
        if (o_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_push_on_pop: got %b expected 0", o_overflow);
        end
      end
    end
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", o_overflow);
    end
    drain();
    repeat (3) nop();
    tick(OP_READ, 16'h0046, '0);
    drain();
    checks++;
    if (last_rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL ovf_dropped: got %h expected 1234", last_rd_data);
    end
    tick(OP_READ, 16'h0045, '0);
    drain();
    checks++;
    if (last_rd_data !== 16'h00C5 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sixth: got %h ovf %b expected 00c5 ovf 1", last_rd_data, o_overflow);
    end
  endtask

  task automatic test_reset_busy();
    tick(OP_WRITE, 16'h0020, 16'h0011);
    drain();
    tick(OP_READ, 16'h0020, '0);
    drain();
    tick(OP_WRITE, 16'h0020, 16'h0077);
    nop();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstb_busy_before: got %b expected 1", o_busy);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({o_rd_valid, o_rd_address, o_rd_data, o_overflow, o_err, o_busy} !== '0) begin
      errors++;
      $display("FAIL rstb_async: got v%b a%h d%h o%b e%b b%b expected all 0",
               o_rd_valid, o_rd_address, o_rd_data, o_overflow, o_err, o_busy);
    end
    @(negedge clk);
    repeat (2) nop();
    rst_n = 1'b1;
    tick(OP_READ, 16'h0020, '0);
    drain();
    checks++;
    if (last_rd_data !== 16'h0011) begin
      errors++;
      $display("FAIL rstb_write_abandoned: got %h expected 0011", last_rd_data);
    end
  endtask

  task automatic test_bounds();
    int            e0;
    logic [AW-1:0] m0;
    logic [AW-1:0] want;
    e0 = err_seen;
    m0 = mmem[0];
    tick(OP_READ, AW'(MW), '0);
    drain();
`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
    want = '0;
`else
    want = m0;
`endif
    checks++;
    if (last_rd_data !== want || last_rd_addr !== AW'(MW)) begin
      errors++;
      $display("FAIL bounds_read: got %h@%h expected %h@%h", last_rd_data, last_rd_addr, want, AW'(MW));
    end
    tick(OP_WRITE, AW'(MW), 16'h5555);
    drain();
    tick(OP_READ, 16'h0000, '0);
    drain();
`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
    want = m0;
`else
    want = 16'h5555;
`endif
    checks++;
    if (last_rd_data !== want) begin
      errors++;
      $display("FAIL bounds_write: got %h expected %h", last_rd_data, want);
    end
    checks++;
`ifdef HANDLE_MEM_BOUNDS_CHECK_EN
    if (err_seen - e0 != 2) begin
      errors++;
      $display("FAIL bounds_err: got %0d pulses expected 2", err_seen - e0);
    end
`else
    if (err_seen - e0 != 0) begin
      errors++;
      $display("FAIL bounds_err: got %0d pulses expected 0", err_seen - e0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = valid_edges.size();
    for (int i = 0; i < 4; i++) tick(OP_READ, AW'($urandom_range(0, MW - 1)), '0);
    drain();
    checks++;
    if (valid_edges.size() - n0 != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 4", valid_edges.size() - n0);
    end else begin
      for (int i = n0 + 1; i < n0 + 4; i++) begin
        checks++;
        if (valid_edges[i] - valid_edges[i-1] != LAT) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d expected %0d", valid_edges[i] - valid_edges[i-1], LAT);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]    op;
    logic [AW-1:0] addr;
    int            k;
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      op = OP_READ;
      else if (k < 5) op = OP_WRITE;
      else begin
        k  = $urandom_range(0, 5);
        op = (k == 0) ? 3'd0 : 3'(k + 2);
      end
      k = $urandom_range(0, 3);
      if (k == 0)      addr = AW'($urandom);
      else if (k == 1) addr = AW'($urandom_range(MW, MW + 3));
      else             addr = AW'($urandom_range(0, 7));
      tick(op, addr, AW'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, LAT)) nop();
    end
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    i_op      = '0;
    i_address = '0;
    i_data    = '0;
    @(negedge clk);
    test_reset();
    preload();
    test_write_read();
    test_noop();
    test_raw();
    test_overflow();
    test_reset_busy();
    test_bounds();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
